systolic_sequencer: RTL

- Instruction-driven controller for the NxN weight-stationary systolic array.
- Accepts 16-bit instructions over a valid/ready handshake and loads weights from the unified buffer into the array.
- Stages activations and feeds them to the array with diagonal skew, so no host-side zero padding is needed.
- Collects column results and writes them back to the unified buffer. Sits between the instruction source and the array/unified buffer.

---
 rtl/systolic_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_sequencer.sv
// Instruction-driven sequencer for an NxN weight-stationary systolic array.
// Optional performance counters are enabled with `define SEQ_PERF_CNT_EN.
module systolic_sequencer #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               instruction,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [ACC_W-1:0]          mem_rd_data,
    output logic                      mem_wr_en,
    output logic [ADDR_W-1:0]         mem_wr_addr,
    output logic [ACC_W-1:0]          mem_wr_data,
    output logic                      w_we,
    output logic [$clog2(N*N)-1:0]    w_idx,
    output logic [DATA_W-1:0]         w_data,
    output logic                      a_valid,
    output logic [N*DATA_W-1:0]       a_in,
    input  logic [N-1:0]              acc_valid,
    input  logic [N*ACC_W-1:0]        acc_in
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]               busy_cycles,
    output logic [15:0]               instr_count
`endif
);

    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int CNT_W = $clog2(NN + 1);
    localparam int CC_W  = $clog2(N + 1);

    localparam logic [CNT_W-1:0] NN_C      = CNT_W'(NN);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(NN - 1);
    localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(2 * N - 2);
    localparam logic [CC_W-1:0]  N_CC      = CC_W'(N);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] W_READ  = 3'd1;
    localparam logic [2:0] IN_READ = 3'd2;
    localparam logic [2:0] FEED    = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;
    localparam logic [2:0] WB      = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] out_base;
    logic [CNT_W-1:0]  cnt;
    logic              done_q;
    logic [DATA_W-1:0] a_stage [NN];
    logic [ACC_W-1:0]  c_res   [NN];
    logic [CC_W-1:0]   col_cnt [N];
    logic              rd_phase;
    logic              capture;
    logic              cols_full;
    logic              unused_bits;

    assign unused_bits = ^{mem_rd_data[ACC_W-1:DATA_W], instruction[12:ADDR_W]};

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign rd_phase    = ((state == W_READ) || (state == IN_READ)) && (cnt < NN_C);
    assign capture     = (state == FEED) || (state == DRAIN);

    always_comb begin
        mem_rd_en   = rd_phase;
        mem_rd_addr = rd_phase ? base_addr + ADDR_W'(cnt) : '0;
        w_we        = (state == W_READ) && (cnt != '0);
        w_idx       = w_we ? IDX_W'(cnt - CNT_W'(1)) : '0;
        w_data      = w_we ? mem_rd_data[DATA_W-1:0] : '0;
        mem_wr_en   = (state == WB);
        mem_wr_addr = mem_wr_en ? out_base + ADDR_W'(cnt) : '0;
        mem_wr_data = mem_wr_en ? c_res[IDX_W'(cnt)] : '0;
        a_valid     = (state == FEED);
        done        = done_q || ((state == W_READ) && (cnt == NN_C))
                             || ((state == WB) && (cnt == LAST_C));
    end

    // Diagonal skew: row i sees column (t - i) of its staged row.
    always_comb begin
        a_in = '0;
        if (state == FEED) begin
            for (int unsigned i = 0; i < N; i++) begin
                if ((int'(cnt) >= int'(i)) && (int'(cnt) - int'(i) < N))
                    a_in[i*DATA_W +: DATA_W] = a_stage[IDX_W'(int'(i) * N + int'(cnt) - int'(i))];
            end
        end
    end

    always_comb begin
        cols_full = 1'b1;
        for (int unsigned j = 0; j < N; j++)
            if (col_cnt[j] != N_CC) cols_full = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base_addr <= '0;
            out_base  <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            err       <= 1'b0;
            a_stage   <= '{default: '0};
            c_res     <= '{default: '0};
            col_cnt   <= '{default: '0};
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        case (instruction[15:13])
                            3'b000: done_q <= 1'b1;
                            3'b001: begin
                                base_addr <= instruction[ADDR_W-1:0];
                                done_q    <= 1'b1;
                            end
                            3'b010: begin
                                state <= W_READ;
                                cnt   <= '0;
                            end
                            3'b011: begin
                                state    <= IN_READ;
                                cnt      <= '0;
                                out_base <= instruction[ADDR_W-1:0];
                                col_cnt  <= '{default: '0};
                            end
                            default: begin
                                err    <= 1'b1;
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                W_READ: begin
                    if (cnt == NN_C) state <= IDLE;
                    else             cnt   <= cnt + 1'b1;
                end
                IN_READ: begin
                    if (cnt != '0)
                        a_stage[IDX_W'(cnt - CNT_W'(1))] <= mem_rd_data[DATA_W-1:0];
                    if (cnt == NN_C) begin
                        state <= FEED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FEED: begin
                    if (cnt == FEED_LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cols_full) begin
                        state <= WB;
                        cnt   <= '0;
                    end
                end
                WB: begin
                    if (cnt == LAST_C) state <= IDLE;
                    else               cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Each column fills its own result rows; extra valids are dropped.
            for (int unsigned j = 0; j < N; j++) begin
                if (capture && acc_valid[j] && (col_cnt[j] != N_CC)) begin
                    c_res[IDX_W'(int'(col_cnt[j]) * N + int'(j))] <= acc_in[j*ACC_W +: ACC_W];
                    col_cnt[j] <= col_cnt[j] + 1'b1;
                end
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cycles <= '0;
            instr_count <= '0;
        end else begin
            if (busy && (busy_cycles != '1)) busy_cycles <= busy_cycles + 1'b1;
            if (instr_valid && instr_ready)  instr_count <= instr_count + 1'b1;
        end
    end
`endif

endmodule
